ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h80000000, first fetch address after reset.
REQ-002 Parameter TIMEOUT, 16, max cycles waiting in WAIT before fetch fault; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  next fetch address from core.
REQ-006 pc_valid  input  1  core presents pc.
REQ-007 pc_ready  output  1  fetch unit accepts pc.
REQ-008 ist  output  32  fetched instruction to core.
REQ-009 ist_valid  output  1  ist/fetch_err valid.
REQ-010 ist_ready  input  1  core consumes ist.
REQ-011 fetch_err  output  1  fetch fault qualified by ist_valid.
REQ-012 imem_req_valid  output  1  instruction-memory request.
REQ-013 imem_req_ready  input  1  memory accepts request.
REQ-014 imem_req_addr  output  32  word-aligned request address.
REQ-015 imem_rsp_valid  input  1  response strobe, one cycle per accepted request.
REQ-016 imem_rsp_data  input  32  response instruction word, little-endian.
REQ-017 imem_rsp_err  input  1  response bus error.
REQ-018 fetch_count  output  32  count of instructions handed to core.

Function
REQ-019 FSM states: BOOT, IDLE, REQ, WAIT, HOLD; exactly one active.
REQ-020 BOOT: one cycle after reset release; loads addr=RESET_PC; -> REQ; pc_ready=0.
REQ-021 IDLE: pc_ready=1; on pc_valid: pc[1:0]==0 -> latch addr=pc, -> REQ; pc[1:0]!=0 -> ist=0, fetch_err=1, -> HOLD, no memory request.
REQ-022 REQ: imem_req_valid=1, imem_req_addr=latched addr, both stable until imem_req_ready; handshake cycle -> WAIT, timeout counter cleared to 0.
REQ-023 WAIT: counter +1 per cycle; imem_rsp_valid -> ist=imem_rsp_data, fetch_err=imem_rsp_err, -> HOLD.
REQ-024 WAIT timeout: counter==TIMEOUT-1 with no rsp -> ist=0, fetch_err=1, -> HOLD; rsp_valid in that same cycle wins (data captured, no fault).
REQ-025 imem_rsp_valid in any state other than WAIT ignored; no state, output or counter change.
REQ-026 HOLD: ist_valid=1, ist and fetch_err stable; on ist_ready -> IDLE, fetch_count +1 (wraps 2^32-1 -> 0), fault fetches included.
REQ-027 pc_ready=1 only in IDLE; imem_req_valid=1 only in REQ; ist_valid=1 only in HOLD.
REQ-028 Latency, zero-wait memory (req_ready=1, rsp next cycle): pc accept at cycle N, req at N+1, rsp at N+2, ist_valid at N+3.
REQ-029 Throughput: at most one outstanding memory request; no new pc accepted before prior ist consumed.
REQ-030 ist_ready outside HOLD ignored; pc_valid outside IDLE ignored (core holds it).

Reset
REQ-031 During reset: state=BOOT, pc_ready=0, ist=0, ist_valid=0, fetch_err=0, imem_req_valid=0, imem_req_addr=0, fetch_count=0, timeout counter=0.
REQ-032 Reset in any state, including REQ/WAIT mid-transaction, aborts it; any later response ignored per REQ-025; fetch restarts from RESET_PC via BOOT.

Verification
REQ-033 Reset release, req_ready=1, rsp next cycle data 32'h00000413 -> req addr 32'h80000000, ist=32'h00000413, ist_valid 3 cycles after BOOT, fetch_err=0.
REQ-034 pc=32'h80000006 in IDLE -> no imem_req_valid, next cycle ist_valid=1, ist=0, fetch_err=1; ist_ready -> fetch_count increments.
REQ-035 req_ready low 5 cycles -> req_valid/addr held constant 5 cycles; handshake on 6th; normal response captured.
REQ-036 TIMEOUT=16, no response -> fetch_err=1, ist=0 exactly 16 cycles after handshake; late rsp_valid then ignored.
REQ-037 imem_rsp_err=1 with data 32'hdeadbeef -> ist=32'hdeadbeef, fetch_err=1; ist_ready held low 10 cycles -> ist_valid, ist stay stable, pc_ready=0.
REQ-038 Reset asserted in WAIT -> all outputs to REQ-031 values; after release fetch of 32'h80000000 reissued; stale rsp before new handshake ignored.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Core-side and instruction-memory-side handshake bundle for the fetch unit.
// master is the fetch unit's view; slave is the core/memory environment's view.
interface ifu_fetch_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] ist;
  logic        ist_valid;
  logic        ist_ready;
  logic        fetch_err;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic [31:0] fetch_count;

  modport master (
    input  pc, pc_valid, ist_ready, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output pc_ready, ist, ist_valid, fetch_err,
           imem_req_valid, imem_req_addr, fetch_count
  );

  modport slave (
    output pc, pc_valid, ist_ready, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  pc_ready, ist, ist_valid, fetch_err,
           imem_req_valid, imem_req_addr, fetch_count
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: takes a pc from the core, issues one
// memory request, waits for the response or a timeout, and holds the result.
//
// state | meaning
// BOOT  | first cycle after reset, loads RESET_PC
// IDLE  | waiting for a pc from the core
// REQ   | memory request presented until accepted
// WAIT  | awaiting response, timeout counter running
// HOLD  | instruction/fault presented until core consumes it
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic clk,
  input  logic reset,
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {BOOT, IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] addr, addr_nxt;
  logic [31:0] ist_r, ist_nxt;
  logic        err_r, err_nxt;
  logic [15:0] tmo, tmo_nxt;
  logic [31:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      addr  <= '0;
      ist_r <= '0;
      err_r <= 1'b0;
      tmo   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      ist_r <= ist_nxt;
      err_r <= err_nxt;
      tmo   <= tmo_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ist_nxt   = ist_r;
    err_nxt   = err_r;
    tmo_nxt   = tmo;
    cnt_nxt   = cnt;
    case (state)
      BOOT: begin
        addr_nxt  = RESET_PC;
        state_nxt = REQ;
      end
      IDLE: begin
        if (bus.pc_valid) begin
          if (bus.pc[1:0] == 2'b00) begin
            addr_nxt  = bus.pc;
            state_nxt = REQ;
          end else begin
            // misaligned pc faults locally without touching memory
            ist_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      REQ: begin
        if (bus.imem_req_ready) begin
          tmo_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // a response arriving on the last allowed cycle beats the timeout
        if (bus.imem_rsp_valid) begin
          ist_nxt   = bus.imem_rsp_data;
          err_nxt   = bus.imem_rsp_err;
          state_nxt = HOLD;
        end else if (tmo == TMO_LAST) begin
          ist_nxt   = '0;
          err_nxt   = 1'b1;
          state_nxt = HOLD;
        end else begin
          tmo_nxt = tmo + 16'd1;
        end
      end
      HOLD: begin
        if (bus.ist_ready) begin
          cnt_nxt   = cnt + 32'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign bus.pc_ready       = (state == IDLE);
  assign bus.imem_req_valid = (state == REQ);
  assign bus.ist_valid      = (state == HOLD);
  assign bus.imem_req_addr  = {addr[31:2], 2'b00};
  assign bus.ist            = ist_r;
  assign bus.fetch_err      = err_r;
  assign bus.fetch_count    = cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot fetch, misaligned pc, request stall,
// timeout edges, error response hold and reset mid-transaction.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    bus.ist_ready = 1'b1;
    tick();
    bus.ist_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    tick(); tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.pc_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pc_ready: got %b want 0", bus.pc_ready); end
    n_cmp++; if (bus.ist_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ist_valid: got %b want 0", bus.ist_valid); end
    n_cmp++; if (bus.ist !== 32'h0) begin n_bad++; $display("FAIL rst_ist: got %h want 0", bus.ist); end
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_err: got %b want 0", bus.fetch_err); end
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    n_cmp++; if (bus.imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr: got %h want 0", bus.imem_req_addr); end
    n_cmp++; if (bus.fetch_count !== 32'h0) begin n_bad++; $display("FAIL rst_fetch_count: got %h want 0", bus.fetch_count); end
  endtask

  task automatic test_boot_fetch();
    bus.imem_req_ready = 1'b1;
    reset = 1'b0;               // BOOT cycle
    tick();                     // REQ
    n_cmp++; if ({bus.imem_req_valid, bus.pc_ready, bus.ist_valid} !== 3'b100) begin n_bad++; $display("FAIL boot_req_flags: got %b want 100", {bus.imem_req_valid, bus.pc_ready, bus.ist_valid}); end
    n_cmp++; if (bus.imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL boot_req_addr: got %h want 80000000", bus.imem_req_addr); end
    tick();                     // WAIT
    n_cmp++; if ({bus.imem_req_valid, bus.ist_valid} !== 2'b00) begin n_bad++; $display("FAIL boot_wait_flags: got %b want 00", {bus.imem_req_valid, bus.ist_valid}); end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0413;
    bus.imem_rsp_err   = 1'b0;
    tick();                     // HOLD, 3 cycles after BOOT
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if (bus.ist_valid !== 1'b1) begin n_bad++; $display("FAIL boot_ist_valid: got %b want 1", bus.ist_valid); end
    n_cmp++; if (bus.ist !== 32'h0000_0413) begin n_bad++; $display("FAIL boot_ist: got %h want 00000413", bus.ist); end
    n_cmp++; if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL boot_fetch_err: got %b want 0", bus.fetch_err); end
    consume();
    n_cmp++; if ({bus.pc_ready, bus.ist_valid} !== 2'b10) begin n_bad++; $display("FAIL boot_idle_flags: got %b want 10", {bus.pc_ready, bus.ist_valid}); end
    n_cmp++; if (bus.fetch_count !== 32'd1) begin n_bad++; $display("FAIL boot_count: got %0d want 1", bus.fetch_count); end
  endtask

  task automatic test_misaligned();
    bus.pc       = 32'h8000_0006;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mis_req_valid: got %b want 0", bus.imem_req_valid); end
    n_cmp++; if ({bus.ist_valid, bus.fetch_err, bus.pc_ready} !== 3'b110) begin n_bad++; $display("FAIL mis_flags: got %b want 110", {bus.ist_valid, bus.fetch_err, bus.pc_ready}); end
    n_cmp++; if (bus.ist !== 32'h0) begin n_bad++; $display("FAIL mis_ist: got %h want 0", bus.ist); end
    consume();
    n_cmp++; if (bus.fetch_count !== 32'd2) begin n_bad++; $display("FAIL mis_count: got %0d want 2", bus.fetch_count); end
  endtask

  task automatic test_req_stall();
    bus.imem_req_ready = 1'b0;
    bus.ist_ready      = 1'b1;  // ignored outside HOLD
    bus.pc       = 32'h8000_0100;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h8000_0100}) begin n_bad++; $display("FAIL stall_hold_%0d: got %b/%h want 1/80000100", i, bus.imem_req_valid, bus.imem_req_addr); end
      tick();
    end
    bus.ist_ready      = 1'b0;
    bus.imem_req_ready = 1'b1;
    n_cmp++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h8000_0100}) begin n_bad++; $display("FAIL stall_6th: got %b/%h want 1/80000100", bus.imem_req_valid, bus.imem_req_addr); end
    tick();
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_wait_req: got %b want 0", bus.imem_req_valid); end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    bus.imem_rsp_err   = 1'b0;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if ({bus.ist_valid, bus.fetch_err, bus.ist} !== {2'b10, 32'h1234_5678}) begin n_bad++; $display("FAIL stall_rsp: got %b%b/%h want 10/12345678", bus.ist_valid, bus.fetch_err, bus.ist); end
    consume();
    n_cmp++; if (bus.fetch_count !== 32'd3) begin n_bad++; $display("FAIL stall_count: got %0d want 3", bus.fetch_count); end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    bus.pc       = 32'h8000_0200;
    bus.pc_valid = 1'b1;
    tick();                     // REQ
    bus.pc_valid = 1'b0;
    tick();                     // handshake edge, WAIT
    for (int i = 0; i < 15; i++) begin
      if (bus.ist_valid) early = 1'b1;
      tick();
    end
    n_cmp++; if ({early, bus.ist_valid} !== 2'b00) begin n_bad++; $display("FAIL tmo_early: got %b want 00", {early, bus.ist_valid}); end
    tick();                     // 16th edge after handshake
    n_cmp++; if ({bus.ist_valid, bus.fetch_err, bus.ist} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL tmo_fault: got %b%b/%h want 11/00000000", bus.ist_valid, bus.fetch_err, bus.ist); end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'haaaa_5555;
    bus.imem_rsp_err   = 1'b0;
    tick();
    n_cmp++; if ({bus.ist_valid, bus.fetch_err, bus.ist} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL tmo_late_rsp: got %b%b/%h want 11/00000000", bus.ist_valid, bus.fetch_err, bus.ist); end
    bus.imem_rsp_valid = 1'b0;
    consume();
    n_cmp++; if (bus.fetch_count !== 32'd4) begin n_bad++; $display("FAIL tmo_count: got %0d want 4", bus.fetch_count); end
    bus.imem_rsp_valid = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if ({bus.pc_ready, bus.ist_valid, bus.imem_req_valid, bus.ist} !== {3'b100, 32'h0}) begin n_bad++; $display("FAIL idle_rsp_ignored: got %b%b%b/%h want 100/00000000", bus.pc_ready, bus.ist_valid, bus.imem_req_valid, bus.ist); end
  endtask

  task automatic test_timeout_edge();
    bus.pc       = 32'h8000_0300;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    tick();                     // WAIT, counter 0
    for (int i = 0; i < 15; i++) tick();
    bus.imem_rsp_valid = 1'b1;  // last WAIT cycle: response must win
    bus.imem_rsp_data  = 32'hcafe_f00d;
    bus.imem_rsp_err   = 1'b0;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if ({bus.ist_valid, bus.fetch_err, bus.ist} !== {2'b10, 32'hcafe_f00d}) begin n_bad++; $display("FAIL tmo_edge_rsp: got %b%b/%h want 10/cafef00d", bus.ist_valid, bus.fetch_err, bus.ist); end
    consume();
    n_cmp++; if (bus.fetch_count !== 32'd5) begin n_bad++; $display("FAIL tmo_edge_count: got %0d want 5", bus.fetch_count); end
  endtask

  task automatic test_rsp_err_hold();
    bus.pc       = 32'h8000_0400;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hdead_beef;
    bus.imem_rsp_err   = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    bus.pc_valid = 1'b1;        // must stay ignored in HOLD
    bus.pc       = 32'h8000_0800;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if ({bus.ist_valid, bus.pc_ready, bus.fetch_err, bus.ist} !== {3'b101, 32'hdead_beef}) begin n_bad++; $display("FAIL err_hold_%0d: got %b%b%b/%h want 101/deadbeef", i, bus.ist_valid, bus.pc_ready, bus.fetch_err, bus.ist); end
      tick();
    end
    bus.pc_valid = 1'b0;
    consume();
    n_cmp++; if ({bus.pc_ready, bus.fetch_count} !== {1'b1, 32'd6}) begin n_bad++; $display("FAIL err_count: got %b/%0d want 1/6", bus.pc_ready, bus.fetch_count); end
  endtask

  task automatic test_reset_in_wait();
    bus.pc       = 32'h8000_0500;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    tick();                     // WAIT
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if ({bus.pc_ready, bus.ist_valid, bus.fetch_err, bus.imem_req_valid, bus.ist, bus.imem_req_addr, bus.fetch_count} !== {4'b0000, 96'h0}) begin n_bad++; $display("FAIL rw_reset_outs: got %b%b%b%b/%h/%h/%h want 0000/0/0/0", bus.pc_ready, bus.ist_valid, bus.fetch_err, bus.imem_req_valid, bus.ist, bus.imem_req_addr, bus.fetch_count); end
    reset = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;  // stale response
    bus.imem_rsp_data  = 32'h1111_1111;
    tick();
    n_cmp++; if ({bus.imem_req_valid, bus.ist_valid, bus.imem_req_addr} !== {2'b10, 32'h8000_0000}) begin n_bad++; $display("FAIL rw_reissue: got %b%b/%h want 10/80000000", bus.imem_req_valid, bus.ist_valid, bus.imem_req_addr); end
    tick();
    n_cmp++; if ({bus.imem_req_valid, bus.ist_valid, bus.imem_req_addr} !== {2'b10, 32'h8000_0000}) begin n_bad++; $display("FAIL rw_stale_ignored: got %b%b/%h want 10/80000000", bus.imem_req_valid, bus.ist_valid, bus.imem_req_addr); end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0513;
    tick();
    bus.imem_rsp_valid = 1'b0;
    n_cmp++; if ({bus.ist_valid, bus.fetch_err, bus.ist} !== {2'b10, 32'h0000_0513}) begin n_bad++; $display("FAIL rw_new_fetch: got %b%b/%h want 10/00000513", bus.ist_valid, bus.fetch_err, bus.ist); end
    consume();
    n_cmp++; if (bus.fetch_count !== 32'd1) begin n_bad++; $display("FAIL rw_count: got %0d want 1", bus.fetch_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.pc             = '0;
    bus.pc_valid       = 1'b0;
    bus.ist_ready      = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    test_reset();
    test_boot_fetch();
    test_misaligned();
    test_req_stall();
    test_timeout();
    test_timeout_edge();
    test_rsp_err_hold();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
